gat_perf_monitor: RTL and testbench

Synthesizable per-layer performance monitor for the GAT accelerator. It replaces bench-side `$time` latency measurement with on-chip cycle counters. For each of `NUM_LAYERS` convolution layers it captures three values: latency (first SPMM valid to first feature-BRAM write), total runtime (first SPMM valid to layer ready) and the number of feature-BRAM writes. The results are exposed through a registered read port that the register bank uses for `gat_debug_*`.

---
 rtl/gat_pkg.sv | 24 ++
 rtl/gat_perf_layer_mon.sv | 185 ++++++++++++++++++
 rtl/gat_perf_monitor.sv | 109 ++++++++++
 tb/tb_gat_perf_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gat_pkg
//  Purpose  : Shared types and constants for the GAT performance monitor.
//             - perf_state_t : per-layer measurement state
//             - PERF_*       : word offsets inside one layer's 4-word read window
//  Revision : 1.0  initial release
// ============================================================================
package gat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_LAT = 2'd1,
        RUN_TOT = 2'd2,
        DONE    = 2'd3
    } perf_state_t;

    localparam logic [1:0] PERF_STATUS = 2'd0;
    localparam logic [1:0] PERF_LAT    = 2'd1;
    localparam logic [1:0] PERF_TOT    = 2'd2;
    localparam logic [1:0] PERF_FCNT   = 2'd3;

endpackage : gat_pkg
`default_nettype wire

// File: rtl/gat_perf_layer_mon.sv
`default_nettype none
// ============================================================================
//  Module   : gat_perf_layer_mon
//  Purpose  : Measurement FSM and counters for one convolution layer.
//             Captures latency (start -> first feature write), total runtime
//             (start -> done) and the number of feature-BRAM writes.
//  Ports    : clk, rst_n      clock, async active-low reset
//             clr            synchronous clear back to IDLE / zero
//             start          layer start level (only looked at in IDLE)
//             feat_ena       feature-BRAM write enable
//             done           layer ready level
//             state          current FSM state
//             busy           layer is in RUN_LAT or RUN_TOT
//             sat            sticky: a counter hit all-ones
//             lat_vld        lat holds a captured value
//             lat/tot/fcnt   captured latency, total runtime, write count
//  Revision : 1.0  initial release
// ============================================================================
module gat_perf_layer_mon
    import gat_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 feat_ena,
    input  logic                 done,
    output perf_state_t          state,
    output logic                 busy,
    output logic                 sat,
    output logic                 lat_vld,
    output logic [CNT_WIDTH-1:0] lat,
    output logic [CNT_WIDTH-1:0] tot,
    output logic [CNT_WIDTH-1:0] fcnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    perf_state_t          r_state;
    perf_state_t          w_state_nxt;

    // r_cyc always holds the elapsed-cycle count of the *current* cycle:
    // 0 in IDLE (and therefore in the start cycle), 1 in the cycle after the
    // start, and so on. Captures can then sample it directly.
    logic [CNT_WIDTH-1:0] r_cyc;
    logic [CNT_WIDTH-1:0] r_lat;
    logic [CNT_WIDTH-1:0] r_tot;
    logic [CNT_WIDTH-1:0] r_fcnt;
    logic                 r_sat;
    logic                 r_lat_vld;

    // Per-cycle control strobes decoded from the FSM
    logic                 w_start;
    logic                 w_run_inc;
    logic                 w_cap_lat;
    logic                 w_cap_tot;
    logic                 w_cnt_feat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run_inc   = 1'b0;
        w_cap_lat   = 1'b0;
        w_cap_tot   = 1'b0;
        w_cnt_feat  = 1'b0;

        case (r_state)
            IDLE: begin
                // done is deliberately not looked at here; a feature write in
                // the start cycle counts and yields a zero latency.
                if (start) begin
                    w_start     = 1'b1;
                    w_cnt_feat  = feat_ena;
                    w_cap_lat   = feat_ena;
                    w_state_nxt = feat_ena ? RUN_TOT : RUN_LAT;
                end
            end
            RUN_LAT: begin
                w_cnt_feat = feat_ena;
                w_cap_lat  = feat_ena;
                if (done) begin
                    w_cap_tot   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_run_inc = 1'b1;
                    if (feat_ena) begin
                        w_state_nxt = RUN_TOT;
                    end
                end
            end
            RUN_TOT: begin
                w_cnt_feat = feat_ena;
                if (done) begin
                    w_cap_tot   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_run_inc = 1'b1;
                end
            end
            DONE: begin
                // held until clr or reset
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc     <= '0;
            r_lat     <= '0;
            r_tot     <= '0;
            r_fcnt    <= '0;
            r_sat     <= 1'b0;
            r_lat_vld <= 1'b0;
        end else if (clr) begin
            r_cyc     <= '0;
            r_lat     <= '0;
            r_tot     <= '0;
            r_fcnt    <= '0;
            r_sat     <= 1'b0;
            r_lat_vld <= 1'b0;
        end else begin
            if (w_start) begin
                r_cyc <= c_cnt_one;
            end else if (w_run_inc) begin
                if (r_cyc == c_cnt_max) begin
                    r_sat <= 1'b1;
                end else begin
                    r_cyc <= r_cyc + c_cnt_one;
                end
            end

            if (w_cap_lat) begin
                r_lat     <= r_cyc;
                r_lat_vld <= 1'b1;
            end

            if (w_cap_tot) begin
                r_tot <= r_cyc;
            end

            if (w_cnt_feat) begin
                if (r_fcnt == c_cnt_max) begin
                    r_sat <= 1'b1;
                end else begin
                    r_fcnt <= r_fcnt + c_cnt_one;
                end
            end
        end
    end

    assign state   = r_state;
    assign busy    = (r_state == RUN_LAT) || (r_state == RUN_TOT);
    assign sat     = r_sat;
    assign lat_vld = r_lat_vld;
    assign lat     = r_lat;
    assign tot     = r_tot;
    assign fcnt    = r_fcnt;

endmodule : gat_perf_layer_mon
`default_nettype wire

// File: rtl/gat_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : gat_perf_monitor
//  Purpose  : Per-layer on-chip performance monitor for the GAT accelerator.
//             One gat_perf_layer_mon per layer plus a registered read port.
//  Ports    : clk, rst_n      clock, async active-low reset
//             clr_i          synchronous clear of all layers
//             start_i        per-layer start level
//             feat_ena_i     per-layer feature-BRAM write enable
//             done_i         per-layer ready level
//             rd_addr_i      {layer, word[1:0]}
//             rd_data_o      registered read data (1-cycle latency)
//             busy_o         per-layer counting flag
//             all_done_o     every layer is in DONE
//  Revision : 1.0  initial release
// ============================================================================
module gat_perf_monitor
    import gat_pkg::*;
#(
    parameter  int NUM_LAYERS = 2,
    parameter  int CNT_WIDTH  = 32,
    localparam int RD_ADDR_W  = $clog2(NUM_LAYERS*4)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic [NUM_LAYERS-1:0] start_i,
    input  logic [NUM_LAYERS-1:0] feat_ena_i,
    input  logic [NUM_LAYERS-1:0] done_i,
    input  logic [RD_ADDR_W-1:0]  rd_addr_i,
    output logic [31:0]           rd_data_o,
    output logic [NUM_LAYERS-1:0] busy_o,
    output logic                  all_done_o
);

    perf_state_t          w_state   [NUM_LAYERS];
    logic                 w_sat     [NUM_LAYERS];
    logic                 w_lat_vld [NUM_LAYERS];
    logic [CNT_WIDTH-1:0] w_lat     [NUM_LAYERS];
    logic [CNT_WIDTH-1:0] w_tot     [NUM_LAYERS];
    logic [CNT_WIDTH-1:0] w_fcnt    [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] w_done_vec;

    logic [31:0]          w_rd_data;
    logic [31:0]          r_rd_data;
    logic [1:0]           w_word;
    int                   w_layer_idx;

    for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
        gat_perf_layer_mon #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_mon (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr_i),
            .start    (start_i[l]),
            .feat_ena (feat_ena_i[l]),
            .done     (done_i[l]),
            .state    (w_state[l]),
            .busy     (busy_o[l]),
            .sat      (w_sat[l]),
            .lat_vld  (w_lat_vld[l]),
            .lat      (w_lat[l]),
            .tot      (w_tot[l]),
            .fcnt     (w_fcnt[l])
        );

        assign w_done_vec[l] = (w_state[l] == DONE);
    end

    assign all_done_o = &w_done_vec;

    // ------------------------------------------------------------------
    // Read mux. The layer field may address more layers than exist when
    // NUM_LAYERS is not a power of two; those addresses fall through to 0.
    // ------------------------------------------------------------------
    assign w_word      = rd_addr_i[1:0];
    assign w_layer_idx = int'(rd_addr_i >> 2);

    always_comb begin
        w_rd_data = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (w_layer_idx == l) begin
                case (w_word)
                    PERF_STATUS: w_rd_data = {26'd0, w_state[l], 1'b0, w_sat[l],
                                              w_lat_vld[l], w_done_vec[l]};
                    PERF_LAT:    w_rd_data[CNT_WIDTH-1:0] = w_lat[l];
                    PERF_TOT:    w_rd_data[CNT_WIDTH-1:0] = w_tot[l];
                    PERF_FCNT:   w_rd_data[CNT_WIDTH-1:0] = w_fcnt[l];
                    default:     w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (clr_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_data;
        end
    end

    assign rd_data_o = r_rd_data;

endmodule : gat_perf_monitor
`default_nettype wire

// File: tb/tb_gat_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gat_perf_monitor
//  Purpose  : Self-checking bench for gat_perf_monitor. Inputs applied since
//             the last clear/reset are recorded per cycle; expected register
//             contents are derived from that history by locating the start,
//             first feature write and done cycles and doing arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gat_perf_monitor;

    localparam int NL  = 3;
    localparam int CW  = 8;
    localparam int AW  = $clog2(NL*4);
    localparam int MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          clr_i;
    logic [NL-1:0] start_i;
    logic [NL-1:0] feat_ena_i;
    logic [NL-1:0] done_i;
    logic [AW-1:0] rd_addr_i;
    logic [31:0]   rd_data_o;
    logic [NL-1:0] busy_o;
    logic          all_done_o;

    gat_perf_monitor #(
        .NUM_LAYERS (NL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .start_i    (start_i),
        .feat_ena_i (feat_ena_i),
        .done_i     (done_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .busy_o     (busy_o),
        .all_done_o (all_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Input history since the last clear or reset, one entry per clock edge
    logic [NL-1:0] qs[$];
    logic [NL-1:0] qf[$];
    logic [NL-1:0] qd[$];

    typedef struct {
        int st;
        bit sat;
        bit lv;
        int lat;
        int tot;
        int fcnt;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected per-layer result from the recorded history
    function automatic exp_t model(input int l);
        exp_t e;
        int s, d, f, n, last, nf;
        e  = '{default: 0};
        s  = -1;
        d  = -1;
        f  = -1;
        nf = 0;
        n  = qs.size();
        for (int t = 0; t < n; t++) if (qs[t][l] && s < 0) s = t;
        if (s < 0) return e;
        for (int t = s + 1; t < n; t++) if (qd[t][l] && d < 0) d = t;
        last = (d < 0) ? n - 1 : d;
        for (int t = s; t <= last; t++) begin
            if (qf[t][l]) begin
                nf++;
                if (f < 0) f = t;
            end
        end
        e.fcnt = (nf > MAX) ? MAX : nf;
        // elapsed count wants to pass MAX in a cycle that still counts
        e.sat  = (nf > MAX) || ((((d < 0) ? n - 1 : d - 1) - s) >= MAX);
        if (f >= 0) begin
            e.lv  = 1'b1;
            e.lat = (f - s > MAX) ? MAX : f - s;
        end
        if (d >= 0) begin
            e.st  = 3;
            e.tot = (d - s > MAX) ? MAX : d - s;
        end else begin
            e.st = (f >= 0) ? 2 : 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        exp_t e;
        int   l;
        int   w;
        l = a >> 2;
        w = a & 3;
        if (l >= NL) return 32'd0;
        e = model(l);
        case (w)
            0:       return {26'd0, 2'(e.st), 1'b0, e.sat, e.lv, (e.st == 3)};
            1:       return 32'(e.lat);
            2:       return 32'(e.tot);
            default: return 32'(e.fcnt);
        endcase
    endfunction

    // One clock cycle: apply inputs, sample #1 after the edge, update history
    task automatic step(input logic [NL-1:0] s, input logic [NL-1:0] f,
                        input logic [NL-1:0] d, input logic c, input logic [AW-1:0] a);
        logic [NL-1:0] eb;
        logic          ead;
        start_i    = s;
        feat_ena_i = f;
        done_i     = d;
        clr_i      = c;
        rd_addr_i  = a;
        @(posedge clk);
        #1;
        if (c) begin
            qs.delete();
            qf.delete();
            qd.delete();
            check("clr_rd", rd_data_o, 32'd0);
        end else begin
            qs.push_back(s);
            qf.push_back(f);
            qd.push_back(d);
        end
        ead = 1'b1;
        for (int l = 0; l < NL; l++) begin
            exp_t e;
            e     = model(l);
            eb[l] = (e.st == 1) || (e.st == 2);
            if (e.st != 3) ead = 1'b0;
        end
        check("busy", 32'(busy_o), 32'(eb));
        check("all_done", 32'(all_done_o), 32'(ead));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        step('0, '0, '0, 1'b0, AW'(a));
        v = rd_data_o;
    endtask

    task automatic read_all();
        logic [31:0] e;
        for (int a = 0; a < (1 << AW); a++) begin
            e = exp_word(a);
            step('0, '0, '0, 1'b0, AW'(a));
            check($sformatf("rd%0d", a), rd_data_o, e);
        end
    endtask

    task automatic do_reset();
        start_i    = '0;
        feat_ena_i = '0;
        done_i     = '0;
        clr_i      = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_all_done", 32'(all_done_o), 32'd0);
        check("rst_rd", rd_data_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qs.delete();
        qf.delete();
        qd.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NL-1:0] s, f, d;
        logic [31:0]   v;

        rst_n      = 1'b0;
        clr_i      = 1'b0;
        start_i    = '0;
        feat_ena_i = '0;
        done_i     = '0;
        rd_addr_i  = '0;
        @(posedge clk);
        #1;
        do_reset();
        read_all();
        do_reset();

        // Three layers, overlapped: layer 1 starts while layer 0 is in RUN_TOT
        for (int t = 0; t <= 40; t++) begin
            s = '0; f = '0; d = '0;
            s[0] = (t == 10); f[0] = (t == 25) || (t == 26); d[0] = (t == 40);
            s[1] = (t == 30); f[1] = (t == 30);              d[1] = (t == 37);
            s[2] = (t == 3);                                 d[2] = (t == 20);
            step(s, f, d, 1'b0, '0);
        end
        rd(0,  v); check("l0_status", v, 32'h33);
        rd(1,  v); check("l0_lat",    v, 32'd15);
        rd(2,  v); check("l0_tot",    v, 32'd30);
        rd(3,  v); check("l0_fcnt",   v, 32'd2);
        rd(4,  v); check("l1_status", v, 32'h33);
        rd(5,  v); check("l1_lat",    v, 32'd0);
        rd(6,  v); check("l1_tot",    v, 32'd7);
        rd(7,  v); check("l1_fcnt",   v, 32'd1);
        rd(8,  v); check("l2_status", v, 32'h31);
        rd(9,  v); check("l2_lat",    v, 32'd0);
        rd(10, v); check("l2_tot",    v, 32'd17);
        rd(11, v); check("l2_fcnt",   v, 32'd0);
        rd(12, v); check("oor_rd",    v, 32'd0);
        check("all_done_hi", 32'(all_done_o), 32'd1);
        read_all();

        // Saturation of the elapsed counter and of the feature counter
        step('0, '0, '0, 1'b1, '0);
        for (int t = 0; t <= 300; t++) begin
            s = '0; f = '0; d = '0;
            s[0] = (t == 0); d[0] = (t == 300);
            s[1] = (t == 0); f[1] = 1'b1; d[1] = (t == 300);
            step(s, f, d, 1'b0, '0);
        end
        rd(0, v); check("sat_l0_status", v, 32'h35);
        rd(2, v); check("sat_l0_tot",    v, 32'd255);
        rd(4, v); check("sat_l1_status", v, 32'h37);
        rd(6, v); check("sat_l1_tot",    v, 32'd255);
        rd(7, v); check("sat_l1_fcnt",   v, 32'd255);
        read_all();

        // Reset mid-RUN_TOT discards the measurement
        step('0, '0, '0, 1'b1, '0);
        step(3'b001, 3'b001, '0, 1'b0, '0);
        idle(10);
        do_reset();
        rd(2, v); check("rst_tot", v, 32'd0);
        read_all();

        // clr coincident with done wins
        step(3'b011, 3'b001, '0, 1'b0, '0);
        idle(5);
        step('0, '0, 3'b011, 1'b1, AW'(2));
        rd(0, v); check("clr_status", v, 32'd0);
        read_all();

        // Randomized epochs, each ended by a clear or a reset
        for (int ep = 0; ep < 24; ep++) begin
            int len;
            len = $urandom_range(40, 220);
            for (int t = 0; t < len; t++) begin
                for (int l = 0; l < NL; l++) begin
                    s[l] = ($urandom_range(0, 7) == 0);
                    f[l] = ($urandom_range(0, 3) == 0);
                    d[l] = ($urandom_range(0, 24) == 0);
                end
                step(s, f, d, 1'b0, AW'($urandom_range(0, (1 << AW) - 1)));
            end
            read_all();
            if ((ep % 3) == 2) begin
                do_reset();
            end else begin
                for (int l = 0; l < NL; l++) begin
                    s[l] = $urandom_range(0, 1) == 1;
                    f[l] = $urandom_range(0, 1) == 1;
                    d[l] = $urandom_range(0, 1) == 1;
                end
                step(s, f, d, 1'b1, AW'($urandom_range(0, (1 << AW) - 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_gat_perf_monitor
`default_nettype wire
